// File: rtl/req_gnt_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : req_gnt_chk_pkg
//  Description : Shared types for the request/grant protocol checker:
//                violation codes, channel FSM states and a latency helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package req_gnt_chk_pkg;

  localparam int unsigned VIOL_CODE_W = 3;

  // Violation codes reported on viol_code; VC_NONE when nothing fired.
  typedef enum logic [VIOL_CODE_W-1:0] {
    VC_NONE     = 3'b000,
    VC_EARLY    = 3'b001,
    VC_TIMEOUT  = 3'b010,
    VC_DROP     = 3'b011,
    VC_SPURIOUS = 3'b100
  } viol_code_t;

  // Per-channel monitor state.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chan_state_t;

  // Latency comparison kept in a function so a zero MIN_LAT does not turn
  // into a constant unsigned "< 0" comparison at the call site.
  function automatic logic lat_below(input int unsigned lat,
                                     input int unsigned min_lat);
    return (lat < min_lat);
  endfunction

endpackage
`default_nettype wire

// File: rtl/req_gnt_chk_chan.sv
`default_nettype none
// ============================================================================
//  Module      : req_gnt_chk_chan
//  Description : One request/grant channel monitor: IDLE/WAIT FSM with a
//                latency counter, producing a combinational violation code.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_gnt_chk_chan
  import req_gnt_chk_pkg::*;
#(
  parameter int unsigned MIN_LAT  = 1,
  parameter int unsigned MAX_LAT  = 4,
  parameter int unsigned REQ_HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dis_i,
  input  logic       req,
  input  logic       gnt,
  output logic       busy,
  output viol_code_t code
);

  localparam int unsigned         LAT_W     = $clog2(MAX_LAT + 1);
  localparam logic [LAT_W-1:0]    C_MAX_LAT = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0]    C_LAT_ONE = LAT_W'(1);

  chan_state_t      state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;

  // State and latency counter registers; reset aborts any open check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state, latency update and violation classification.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    code    = VC_NONE;
    if (dis_i) begin
      state_d = IDLE;
      lat_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt) begin
            // Grant with no open request: zero-latency grant or spurious.
            if (req) code = (MIN_LAT == 0) ? VC_NONE : VC_EARLY;
            else     code = VC_SPURIOUS;
          end else if (req) begin
            state_d = WAIT;
            lat_d   = C_LAT_ONE;
          end
        end
        WAIT: begin
          if (gnt) begin
            code    = lat_below(32'(lat_q), MIN_LAT) ? VC_EARLY : VC_NONE;
            state_d = IDLE;
            lat_d   = '0;
          end else if ((REQ_HOLD != 0) && !req) begin
            code    = VC_DROP;
            state_d = IDLE;
            lat_d   = '0;
          end else if (lat_q == C_MAX_LAT) begin
            code    = VC_TIMEOUT;
            state_d = IDLE;
            lat_d   = '0;
          end else begin
            lat_d = lat_q + C_LAT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          lat_d   = '0;
        end
      endcase
    end
  end

  assign busy = (state_q == WAIT);

endmodule
`default_nettype wire

// File: rtl/req_gnt_checker.sv
`default_nettype none
// ============================================================================
//  Module      : req_gnt_checker
//  Description : Multi-channel request/grant latency monitor with registered
//                violation pulses/codes, sticky flags and a saturating
//                violation counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module req_gnt_checker
  import req_gnt_chk_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned MIN_LAT  = 1,
  parameter int unsigned MAX_LAT  = 4,
  parameter int unsigned REQ_HOLD = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dis_i,
  input  logic                  err_clr,
  input  logic [NUM_CH-1:0]     req,
  input  logic [NUM_CH-1:0]     gnt,
  output logic [NUM_CH-1:0]     busy,
  output logic [NUM_CH-1:0]     viol_pulse,
  output logic [3*NUM_CH-1:0]   viol_code,
  output logic [NUM_CH-1:0]     err_sticky,
  output logic [CNT_W-1:0]      viol_cnt
);

  generate
    if ((MIN_LAT > MAX_LAT) || (MAX_LAT < 1) || (NUM_CH < 1)) begin : g_param_err
      $error("req_gnt_checker: illegal parameters (need NUM_CH>=1, MAX_LAT>=1, MIN_LAT<=MAX_LAT)");
    end
  endgenerate

  viol_code_t ch_code [NUM_CH];

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      req_gnt_chk_chan #(
        .MIN_LAT  (MIN_LAT),
        .MAX_LAT  (MAX_LAT),
        .REQ_HOLD (REQ_HOLD)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .dis_i (dis_i),
        .req   (req[i]),
        .gnt   (gnt[i]),
        .busy  (busy[i]),
        .code  (ch_code[i])
      );
    end
  endgenerate

  logic [NUM_CH-1:0]   viol_pulse_q, viol_pulse_d;
  logic [3*NUM_CH-1:0] viol_code_q,  viol_code_d;
  logic [NUM_CH-1:0]   err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0]    viol_cnt_q,   viol_cnt_d;
  logic [CNT_W-1:0]    cnt_base;
  logic [CNT_W:0]      viol_pop;
  logic [CNT_W:0]      cnt_sum;

  // Gather channel codes, update sticky flags and the saturating counter.
  always_comb begin
    viol_pulse_d = '0;
    viol_code_d  = '0;
    viol_pop     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      viol_pulse_d[i]      = (ch_code[i] != VC_NONE);
      viol_code_d[3*i +: 3] = ch_code[i];
      viol_pop             = viol_pop + {{CNT_W{1'b0}}, viol_pulse_d[i]};
    end
    // A clear and a new violation together leave the flag set.
    err_sticky_d = (err_clr ? '0 : err_sticky_q) | viol_pulse_d;
    cnt_base     = err_clr ? '0 : viol_cnt_q;
    cnt_sum      = {1'b0, cnt_base} + viol_pop;
    viol_cnt_d   = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // Output and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      viol_pulse_q <= '0;
      viol_code_q  <= '0;
      err_sticky_q <= '0;
      viol_cnt_q   <= '0;
    end else begin
      viol_pulse_q <= viol_pulse_d;
      viol_code_q  <= viol_code_d;
      err_sticky_q <= err_sticky_d;
      viol_cnt_q   <= viol_cnt_d;
    end
  end

  assign viol_pulse = viol_pulse_q;
  assign viol_code  = viol_code_q;
  assign err_sticky = err_sticky_q;
  assign viol_cnt   = viol_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_req_gnt_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_req_gnt_checker
//  Description : Self-checking bench for req_gnt_checker: a cycle-by-cycle
//                vector table on the default instance plus hand sequences for
//                saturation, reset mid-check and the req |=> gnt instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_req_gnt_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dis_i = 1'b0;
  logic        err_clr = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt = '0;
  logic [3:0]  busy, pulse, sticky;
  logic [11:0] code;
  logic [7:0]  cnt;

  logic [0:0]  req1 = '0;
  logic [0:0]  gnt1 = '0;
  logic [0:0]  busy1, pulse1, sticky1;
  logic [2:0]  code1;
  logic [3:0]  cnt1;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  req_gnt_checker #(
    .NUM_CH(4), .MIN_LAT(1), .MAX_LAT(4), .REQ_HOLD(1), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .dis_i(dis_i), .err_clr(err_clr),
    .req(req), .gnt(gnt), .busy(busy), .viol_pulse(pulse),
    .viol_code(code), .err_sticky(sticky), .viol_cnt(cnt)
  );

  req_gnt_checker #(
    .NUM_CH(1), .MIN_LAT(1), .MAX_LAT(1), .REQ_HOLD(0), .CNT_W(4)
  ) dut1 (
    .clk(clk), .rst(rst), .dis_i(dis_i), .err_clr(err_clr),
    .req(req1), .gnt(gnt1), .busy(busy1), .viol_pulse(pulse1),
    .viol_code(code1), .err_sticky(sticky1), .viol_cnt(cnt1)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        dis;
    logic        clr;
    logic [3:0]  busy;
    logic [3:0]  pulse;
    logic [11:0] code;
    logic [3:0]  sticky;
    logic [7:0]  cnt;
  } vec_t;

  localparam int N_VEC = 38;
  vec_t vecs [N_VEC];

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] g,
                              input logic d, input logic c,
                              input logic [3:0] b, input logic [3:0] p,
                              input logic [11:0] cd, input logic [3:0] s,
                              input logic [7:0] n);
    vec_t v;
    v.req = r; v.gnt = g; v.dis = d; v.clr = c;
    v.busy = b; v.pulse = p; v.code = cd; v.sticky = s; v.cnt = n;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, sample just after the next rising edge.
  task automatic step(input logic [3:0] r, input logic [3:0] g,
                      input logic d, input logic c);
    @(negedge clk);
    req = r; gnt = g; dis_i = d; err_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic r, input logic g);
    @(negedge clk);
    req1 = r; gnt1 = g;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input logic [3:0] b, input logic [3:0] p,
                         input logic [11:0] cd, input logic [3:0] s,
                         input logic [7:0] n);
    chk("busy",       idx, 32'(busy),   32'(b));
    chk("viol_pulse", idx, 32'(pulse),  32'(p));
    chk("viol_code",  idx, 32'(code),   32'(cd));
    chk("err_sticky", idx, 32'(sticky), 32'(s));
    chk("viol_cnt",   idx, 32'(cnt),    32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //            req   gnt   dis   clr   busy  pulse code    stky  cnt
    // ch0 granted at latency 3: no violation
    vecs[0]  = mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[1]  = mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[2]  = mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[3]  = mk(4'h1, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[4]  = mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'h0, 8'd0);
    // ch1 held, never granted: TIMEOUT after lat reaches 4
    vecs[5]  = mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[6]  = mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[7]  = mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[8]  = mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h2, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[9]  = mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 4'h2, 12'h010, 4'h2, 8'd1);
    vecs[10] = mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'h2, 8'd1);
    // ch2: EARLY (latency 0), DROP at lat 2, SPURIOUS
    vecs[11] = mk(4'h4, 4'h4, 1'b0, 1'b0, 4'h0, 4'h4, 12'h040, 4'h6, 8'd2);
    vecs[12] = mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'h6, 8'd2);
    vecs[13] = mk(4'h4, 4'h0, 1'b0, 1'b0, 4'h4, 4'h0, 12'h000, 4'h6, 8'd2);
    vecs[14] = mk(4'h4, 4'h0, 1'b0, 1'b0, 4'h4, 4'h0, 12'h000, 4'h6, 8'd2);
    vecs[15] = mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h4, 12'h0C0, 4'h6, 8'd3);
    vecs[16] = mk(4'h0, 4'h4, 1'b0, 1'b0, 4'h0, 4'h4, 12'h100, 4'h6, 8'd4);
    vecs[17] = mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'h6, 8'd4);
    // all four channels time out together: counter +4
    vecs[18] = mk(4'hF, 4'h0, 1'b0, 1'b0, 4'hF, 4'h0, 12'h000, 4'h6, 8'd4);
    vecs[19] = mk(4'hF, 4'h0, 1'b0, 1'b0, 4'hF, 4'h0, 12'h000, 4'h6, 8'd4);
    vecs[20] = mk(4'hF, 4'h0, 1'b0, 1'b0, 4'hF, 4'h0, 12'h000, 4'h6, 8'd4);
    vecs[21] = mk(4'hF, 4'h0, 1'b0, 1'b0, 4'hF, 4'h0, 12'h000, 4'h6, 8'd4);
    vecs[22] = mk(4'hF, 4'h0, 1'b0, 1'b0, 4'h0, 4'hF, 12'h492, 4'hF, 8'd8);
    vecs[23] = mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'hF, 8'd8);
    // disable mid-WAIT, resume, and disable masking spurious grants
    vecs[24] = mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 12'h000, 4'hF, 8'd8);
    vecs[25] = mk(4'h1, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 12'h000, 4'hF, 8'd8);
    vecs[26] = mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 12'h000, 4'hF, 8'd8);
    vecs[27] = mk(4'h1, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'hF, 8'd8);
    vecs[28] = mk(4'h0, 4'hF, 1'b1, 1'b0, 4'h0, 4'h0, 12'h000, 4'hF, 8'd8);
    vecs[29] = mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'hF, 8'd8);
    // err_clr with simultaneous violations, then plain clear
    vecs[30] = mk(4'h0, 4'h3, 1'b0, 1'b1, 4'h0, 4'h3, 12'h024, 4'h3, 8'd2);
    vecs[31] = mk(4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[32] = mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'h0, 8'd0);
    // ch3 granted exactly at MAX_LAT: legal
    vecs[33] = mk(4'h8, 4'h0, 1'b0, 1'b0, 4'h8, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[34] = mk(4'h8, 4'h0, 1'b0, 1'b0, 4'h8, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[35] = mk(4'h8, 4'h0, 1'b0, 1'b0, 4'h8, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[36] = mk(4'h8, 4'h0, 1'b0, 1'b0, 4'h8, 4'h0, 12'h000, 4'h0, 8'd0);
    vecs[37] = mk(4'h8, 4'h8, 1'b0, 1'b0, 4'h0, 4'h0, 12'h000, 4'h0, 8'd0);

    // Reset: assert asynchronously, hold for a few edges.
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all(-1, 4'h0, 4'h0, 12'h000, 4'h0, 8'd0);
    chk("reset_busy1", -1, 32'(busy1), 32'd0);
    chk("reset_cnt1",  -1, 32'(cnt1),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < N_VEC; i++) begin
      step(vecs[i].req, vecs[i].gnt, vecs[i].dis, vecs[i].clr);
      chk_all(i, vecs[i].busy, vecs[i].pulse, vecs[i].code,
              vecs[i].sticky, vecs[i].cnt);
    end

    // Counter saturation: 63 cycles of 4 spurious grants, then +2 = 254.
    for (int k = 0; k < 63; k++) step(4'h0, 4'hF, 1'b0, 1'b0);
    step(4'h0, 4'h3, 1'b0, 1'b0);
    chk("sat_254", 0, 32'(cnt), 32'd254);
    step(4'h0, 4'hF, 1'b0, 1'b0);
    chk("sat_255", 0, 32'(cnt), 32'd255);
    chk("sat_sticky", 0, 32'(sticky), 32'hF);
    step(4'h0, 4'h1, 1'b0, 1'b0);
    chk("sat_hold", 0, 32'(cnt), 32'd255);

    // Reset mid-WAIT: everything drops immediately, nothing reported after.
    step(4'h1, 4'h2, 1'b0, 1'b0);
    chk("pre_rst_busy",  0, 32'(busy),  32'h1);
    chk("pre_rst_pulse", 0, 32'(pulse), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk_all(100, 4'h0, 4'h0, 12'h000, 4'h0, 8'd0);
    @(posedge clk);
    @(negedge clk);
    req = 4'h0; gnt = 4'h0;
    rst = 1'b1;
    step(4'h0, 4'h0, 1'b0, 1'b0);
    chk_all(101, 4'h0, 4'h0, 12'h000, 4'h0, 8'd0);
    step(4'h0, 4'h0, 1'b0, 1'b0);
    chk_all(102, 4'h0, 4'h0, 12'h000, 4'h0, 8'd0);

    // req |=> gnt instance: exact one-cycle grant passes.
    step1(1'b1, 1'b0);
    chk("d1_busy", 0, 32'(busy1), 32'd1);
    step1(1'b0, 1'b1);
    chk("d1_pass_pulse", 0, 32'(pulse1), 32'd0);
    chk("d1_pass_busy",  0, 32'(busy1),  32'd0);
    // Grant two cycles late: TIMEOUT, then the grant itself is SPURIOUS.
    step1(1'b1, 1'b0);
    step1(1'b0, 1'b0);
    chk("d1_to_pulse", 0, 32'(pulse1), 32'd1);
    chk("d1_to_code",  0, 32'(code1),  32'b010);
    chk("d1_to_cnt",   0, 32'(cnt1),   32'd1);
    step1(1'b0, 1'b1);
    chk("d1_sp_pulse", 0, 32'(pulse1),  32'd1);
    chk("d1_sp_code",  0, 32'(code1),   32'b100);
    chk("d1_sp_cnt",   0, 32'(cnt1),    32'd2);
    chk("d1_sticky",   0, 32'(sticky1), 32'd1);
    step1(1'b0, 1'b0);
    chk("d1_idle_pulse", 0, 32'(pulse1), 32'd0);
    chk("d1_idle_code",  0, 32'(code1),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
